// File: rtl/nnrv_pkg.sv
// rtl/nnrv_pkg.sv - shared widths and types for the operand-fetch stage
package nnrv_pkg;

    localparam int XLEN      = 32;
    localparam int REG_NUM   = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;

    // Operand source select: x0 and unused operands read as zero, writeback data wins over the regfile
    function automatic xdata_t sel_operand(
        input logic     en,
        input reg_idx_t idx,
        input logic     wb_hit,
        input xdata_t   wb_data,
        input xdata_t   rf_data
    );
        if (!en || idx == '0) begin
            return '0;
        end
        if (wb_hit) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/nnrv_scoreboard.sv
// rtl/nnrv_scoreboard.sv - per-register pending bits with one set and two clear ports
module nnrv_scoreboard
    import nnrv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               set_en,
    input  reg_idx_t           set_idx,
    input  logic               clr_en,
    input  reg_idx_t           clr_idx,
    input  logic               clr2_en,
    input  reg_idx_t           clr2_idx,
    output logic [REG_NUM-1:0] pending,
    output logic               o_busy
);

    logic [REG_NUM-1:0] sb_q;
    logic [REG_NUM-1:0] sb_d;

    // A set beats a clear on the same index: the new writer's bit must survive the old writeback
    always_comb begin
        sb_d = sb_q;
        for (int i = 1; i < REG_NUM; i++) begin
            if (set_en && set_idx == reg_idx_t'(i)) begin
                sb_d[i] = 1'b1;
            end else if ((clr_en && clr_idx == reg_idx_t'(i)) ||
                         (clr2_en && clr2_idx == reg_idx_t'(i))) begin
                sb_d[i] = 1'b0;
            end
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign pending = sb_q;
    assign o_busy  = |sb_q;

endmodule

// File: rtl/nnrv_opfetch.sv
// rtl/nnrv_opfetch.sv - operand fetch/issue stage with hazard stall and writeback forwarding
module nnrv_opfetch
    import nnrv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_dec_valid,
    output logic            o_dec_ready,
    input  logic            i_rs1_en,
    input  logic [4:0]      i_rs1,
    input  logic            i_rs2_en,
    input  logic [4:0]      i_rs2,
    input  logic            i_rd_en,
    input  logic [4:0]      i_rd,
    output logic            o_r1_en,
    output logic [4:0]      o_r1,
    output logic            o_r2_en,
    output logic [4:0]      o_r2,
    input  logic [XLEN-1:0] i_r1_reg,
    input  logic [XLEN-1:0] i_r2_reg,
    input  logic            i_w_en,
    input  logic [4:0]      i_w,
    input  logic [XLEN-1:0] i_w_reg,
    input  logic            i_flush,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic            o_rd_en,
    output logic [4:0]      o_rd,
    output logic            o_busy
);

    logic [REG_NUM-1:0] pending;
    logic               wb_valid;
    logic               hit_rs1;
    logic               hit_rs2;
    logic               hit_rd;
    logic               hazard;
    logic               accept;
    logic               set_en;
    logic               clr2_en;

    assign o_r1_en = i_rs1_en;
    assign o_r1    = i_rs1;
    assign o_r2_en = i_rs2_en;
    assign o_r2    = i_rs2;

    assign wb_valid = i_w_en && (i_w != '0);
    assign hit_rs1  = wb_valid && (i_w == i_rs1);
    assign hit_rs2  = wb_valid && (i_w == i_rs2);
    assign hit_rd   = wb_valid && (i_w == i_rd);

    // A writeback landing this cycle resolves its own hazard, so it does not stall
    assign hazard = (i_rs1_en && pending[i_rs1] && !hit_rs1) ||
                    (i_rs2_en && pending[i_rs2] && !hit_rs2) ||
                    (i_rd_en  && pending[i_rd]  && !hit_rd);

    assign o_dec_ready = !i_flush && !hazard && (!o_ex_valid || i_ex_ready);
    assign accept      = i_dec_valid && o_dec_ready;

    assign set_en  = accept && i_rd_en && (i_rd != '0);
    // A flushed instruction never issued, so nobody will ever write its rd back
    assign clr2_en = i_flush && o_ex_valid && o_rd_en && (o_rd != '0);

    nnrv_scoreboard u_sb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .set_en   (set_en),
        .set_idx  (i_rd),
        .clr_en   (wb_valid),
        .clr_idx  (i_w),
        .clr2_en  (clr2_en),
        .clr2_idx (o_rd),
        .pending  (pending),
        .o_busy   (o_busy)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ex_valid <= 1'b0;
            o_op1      <= '0;
            o_op2      <= '0;
            o_rd_en    <= 1'b0;
            o_rd       <= '0;
        end else if (i_flush) begin
            o_ex_valid <= 1'b0;
        end else if (accept) begin
            o_ex_valid <= 1'b1;
            o_op1      <= sel_operand(i_rs1_en, i_rs1, hit_rs1, i_w_reg, i_r1_reg);
            o_op2      <= sel_operand(i_rs2_en, i_rs2, hit_rs2, i_w_reg, i_r2_reg);
            o_rd_en    <= i_rd_en;
            o_rd       <= i_rd;
        end else if (o_ex_valid && i_ex_ready) begin
            o_ex_valid <= 1'b0;
        end
    end

endmodule
